vsw_wrr_scheduler: RTL and testbench
====================================

# vsw_wrr_scheduler

Weighted round-robin packet scheduler that decides which virtual-switch output queue may drive the shared output merge stage toward the output queues. It takes per-queue non-empty requests, grants exactly one queue per packet, holds the grant until end-of-packet and allows each queue up to its configured weight of back-to-back packets per turn. It sequences the merge multiplexer and replaces free-running queue polling with a registered one-hot grant.

## Interface
Parameters:
- NUM_QUEUES, 5, number of requesting queues, range 2..16
- WEIGHT_WIDTH, 4, bits per queue weight; weight = packets per turn, 0 = queue disabled
- IDX_WIDTH, 3, width of grant_idx, ≥ ceil(log2(NUM_QUEUES))

Ports:
- axis_aclk  in  1  clock; all logic on rising edge
- axis_reset  in  1  asynchronous, active-high reset
- req  in  NUM_QUEUES  bit i high = queue i holds at least one word (FIFO not empty)
- weight_cfg  in  NUM_QUEUES*WEIGHT_WIDTH  weight of queue i in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- pkt_end  in  1  merge output accepted the last beat (tvalid & tready & tlast)
- grant  out  NUM_QUEUES  registered one-hot grant; all-zero = none
- grant_idx  out  IDX_WIDTH  binary index of granted queue; 0 when none
- grant_valid  out  1  OR of grant
- cnt_sel  in  IDX_WIDTH  queue selected for counter readout
- cnt_out  out  16  packet count of queue cnt_sel; see Configuration

## Operation
- Eligible(i) = req[i] & (weight_i != 0).
- State IDLE (grant_valid = 0): search for an eligible queue starting at last_ptr+1 and wrapping modulo NUM_QUEUES; last_ptr is included last. The first hit becomes granted, credit = weight − 1, last_ptr = index, state → BUSY. If there is no hit, stay in IDLE.
- State BUSY: the grant is frozen regardless of req or weight_cfg changes. On pkt_end:
  - if credit ≠ 0 and eligible(current): keep the grant and decrement credit.
  - else: run the IDLE search from current+1. On a hit, grant the new queue (the current queue may be regranted only if it is the sole eligible one) and reload credit from its weight. On no hit, go to IDLE.
- pkt_end in IDLE is ignored and has no state change.
- weight_cfg is sampled only at grant or reload. Changing it mid-turn does not affect the running credit.
- Credit is WEIGHT_WIDTH bits wide and never underflows; the decrement happens only when credit ≠ 0.
- Reset state: IDLE, grant = 0, grant_idx = 0, grant_valid = 0, last_ptr = NUM_QUEUES−1 (so queue 0 is searched first), credit = 0, counters = 0, cnt_out = 0.

## Timing
- IDLE → grant: eligible req high in cycle N gives grant valid in cycle N+1.
- Packet boundary: pkt_end in cycle N makes the next grant (or none) visible in cycle N+1, with no extra bubble cycle.
- A single-beat packet is legal: pkt_end may occur in the first cycle of a grant.
- When pkt_end and a req change coincide in cycle N, the cycle-N req value is used.
- Reset asserted mid-packet clears the grant immediately (asynchronously). The first grant after release comes no earlier than the second rising edge after deassertion.
- The grant is never all-ones or multi-hot. grant, grant_idx and grant_valid come straight from flops, with no combinational path from inputs.

## Configuration
- SCHED_PKT_CNT_EN defined: one 16-bit saturating counter per queue, incremented on pkt_end while that queue is granted and holding at 0xFFFF. cnt_out is the registered value of counter cnt_sel with 1-cycle latency; an out-of-range cnt_sel reads 0.
- SCHED_PKT_CNT_EN undefined: no counters are built, cnt_out is constant 0 and cnt_sel is ignored. Scheduling behaviour is identical in both builds.

## Test plan
- Reset release, req=5'b00100, all weights 1 → grant=5'b00100 and grant_idx=2 one cycle after req; pkt_end → next cycle grant=5'b00100 again (sole eligible queue).
- req=5'b11111, weights all 1, pkt_end every 3 cycles → grant order 0,1,2,3,4,0 with no idle cycle between grants.
- weights q0=3, q1=1, req=5'b00011 steady → grant sequence 0,0,0,1,0,0,0,1 over 8 packets.
- q3 weight=0 with req[3]=1 only → grant_valid stays 0 for 100 cycles; set weight to 2 → grant=5'b01000 the next cycle.
- Grant q1, drop req[1] and raise req[4] mid-packet → grant holds at q1 until pkt_end, then q4; assert axis_reset during q4's packet → grant=0 immediately and q0 has priority after release.
- With SCHED_PKT_CNT_EN: 5 packets on q2, cnt_sel=2 → cnt_out=5 one cycle later; preload q2's count to 0xFFFE and send 3 packets → cnt_out=0xFFFF. Without the macro, cnt_out=0 in both cases.

Source files
------------

// File: rtl/vsw_wrr_scheduler.sv
// Weighted round-robin packet scheduler for the virtual-switch output merge stage.
// Optional per-queue packet counters are built when SCHED_PKT_CNT_EN is defined.
module vsw_wrr_scheduler #(
    parameter int NUM_QUEUES   = 5,
    parameter int WEIGHT_WIDTH = 4,
    parameter int IDX_WIDTH    = 3
) (
    input  logic                               axis_aclk,
    input  logic                               axis_reset,
    input  logic [NUM_QUEUES-1:0]              req,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weight_cfg,
    input  logic                               pkt_end,
    output logic [NUM_QUEUES-1:0]              grant,
    output logic [IDX_WIDTH-1:0]               grant_idx,
    output logic                               grant_valid,
    input  logic [IDX_WIDTH-1:0]               cnt_sel,
    output logic [15:0]                        cnt_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_QUEUES-1:0]   r_grant;
    logic [NUM_QUEUES-1:0]   w_grant_next;
    logic                    r_grant_valid;
    logic [IDX_WIDTH-1:0]    r_grant_idx;
    logic [IDX_WIDTH-1:0]    w_grant_idx_next;
    logic [IDX_WIDTH-1:0]    r_last_ptr;
    logic [IDX_WIDTH-1:0]    w_last_ptr_next;
    logic [WEIGHT_WIDTH-1:0] r_credit;
    logic [WEIGHT_WIDTH-1:0] w_credit_next;
    // Holds off the first grant for one edge after reset release.
    logic                    r_arm;

    logic [WEIGHT_WIDTH-1:0] w_weight [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]   w_elig;
    logic                    w_hit;
    logic [IDX_WIDTH-1:0]    w_hit_idx;
    logic [WEIGHT_WIDTH-1:0] w_hit_weight;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : gen_elig
            assign w_weight[gi] = weight_cfg[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            assign w_elig[gi]   = req[gi] & (|w_weight[gi]);
        end
    endgenerate

    // In BUSY last_ptr equals the current queue, so one search serves both states.
    always_comb begin
        int                   p;
        logic [IDX_WIDTH-1:0] cand;
        p         = 0;
        cand      = '0;
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            p = int'(r_last_ptr) + k;
            if (p >= NUM_QUEUES) begin
                p = p - NUM_QUEUES;
            end
            cand = IDX_WIDTH'(p);
            if (!w_hit && w_elig[cand]) begin
                w_hit     = 1'b1;
                w_hit_idx = cand;
            end
        end
    end

    assign w_hit_weight = w_weight[w_hit_idx];

    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_grant_idx_next = r_grant_idx;
        w_last_ptr_next  = r_last_ptr;
        w_credit_next    = r_credit;
        case (r_state)
            ST_IDLE: begin
                if (w_hit && !r_arm) begin
                    w_state_next     = ST_BUSY;
                    w_grant_next     = {{(NUM_QUEUES-1){1'b0}}, 1'b1} << w_hit_idx;
                    w_grant_idx_next = w_hit_idx;
                    w_last_ptr_next  = w_hit_idx;
                    w_credit_next    = w_hit_weight - 1'b1;
                end
            end
            ST_BUSY: begin
                if (pkt_end) begin
                    if ((r_credit != '0) && w_elig[r_grant_idx]) begin
                        w_credit_next = r_credit - 1'b1;
                    end else if (w_hit) begin
                        w_grant_next     = {{(NUM_QUEUES-1){1'b0}}, 1'b1} << w_hit_idx;
                        w_grant_idx_next = w_hit_idx;
                        w_last_ptr_next  = w_hit_idx;
                        w_credit_next    = w_hit_weight - 1'b1;
                    end else begin
                        w_state_next     = ST_IDLE;
                        w_grant_next     = '0;
                        w_grant_idx_next = '0;
                        w_credit_next    = '0;
                    end
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_grant_next     = '0;
                w_grant_idx_next = '0;
                w_credit_next    = '0;
            end
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_last_ptr    <= IDX_WIDTH'(NUM_QUEUES - 1);
            r_credit      <= '0;
            r_arm         <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_grant_valid <= |w_grant_next;
            r_grant_idx   <= w_grant_idx_next;
            r_last_ptr    <= w_last_ptr_next;
            r_credit      <= w_credit_next;
            r_arm         <= 1'b0;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;

`ifdef SCHED_PKT_CNT_EN
    logic [15:0] w_cnt [NUM_QUEUES];
    logic [15:0] r_cnt_out;

    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : gen_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge axis_aclk or posedge axis_reset) begin
                if (axis_reset) begin
                    r_cnt <= 16'h0000;
                end else if (pkt_end && r_grant[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'h0001;
                end
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_cnt_out <= 16'h0000;
        end else if (int'(cnt_sel) < NUM_QUEUES) begin
            r_cnt_out <= w_cnt[cnt_sel];
        end else begin
            r_cnt_out <= 16'h0000;
        end
    end

    assign cnt_out = r_cnt_out;
`else
    logic w_unused_cnt_sel;
    assign w_unused_cnt_sel = ^cnt_sel;
    assign cnt_out          = 16'h0000;
`endif

endmodule

// File: tb/tb_vsw_wrr_scheduler.sv
// Directed bench for vsw_wrr_scheduler: vector table for steady scheduling plus
// hand sequences for disabled weights, mid-packet req changes, reset and counters.
module tb_vsw_wrr_scheduler;

    logic        axis_aclk;
    logic        axis_reset;
    logic [4:0]  req;
    logic [19:0] weight_cfg;
    logic        pkt_end;
    logic [4:0]  grant;
    logic [2:0]  grant_idx;
    logic        grant_valid;
    logic [2:0]  cnt_sel;
    logic [15:0] cnt_out;

    int n_checks;
    int n_fail;

`ifdef SCHED_PKT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [19:0] W_ALL1 = 20'h11111;

    typedef struct {
        logic [4:0]  req;
        logic [19:0] wcfg;
        logic        pe;
        logic [4:0]  exp_grant;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];

    vsw_wrr_scheduler #(
        .NUM_QUEUES  (5),
        .WEIGHT_WIDTH(4),
        .IDX_WIDTH   (3)
    ) dut (
        .axis_aclk  (axis_aclk),
        .axis_reset (axis_reset),
        .req        (req),
        .weight_cfg (weight_cfg),
        .pkt_end    (pkt_end),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .cnt_sel    (cnt_sel),
        .cnt_out    (cnt_out)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    task automatic tick();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    task automatic check_grant(input string name, input logic [4:0] g, input logic [2:0] idx);
        check({name, ".grant"}, 32'(grant), 32'(g));
        check({name, ".idx"}, 32'(grant_idx), 32'(idx));
        check({name, ".valid"}, 32'(grant_valid), 32'(|g));
    endtask

    function automatic void add(input logic [4:0] r, input logic [19:0] w, input logic pe,
                                input logic [4:0] g, input logic [2:0] idx);
        vec_t v;
        v.req       = r;
        v.wcfg      = w;
        v.pe        = pe;
        v.exp_grant = g;
        v.exp_idx   = idx;
        vecs.push_back(v);
    endfunction

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        axis_reset = 1'b1;
        req        = 5'b0;
        weight_cfg = W_ALL1;
        pkt_end    = 1'b0;
        cnt_sel    = 3'd0;

        // Round robin, all weights 1, pkt_end every third cycle: 0,1,2,3,4,0.
        for (int k = 0; k < 5; k++) begin
            add(5'b11111, W_ALL1, (k > 0), 5'(1 << k), 3'(k));
            add(5'b11111, W_ALL1, 1'b0,    5'(1 << k), 3'(k));
            add(5'b11111, W_ALL1, 1'b0,    5'(1 << k), 3'(k));
        end
        add(5'b11111, W_ALL1, 1'b1, 5'b00001, 3'd0);
        add(5'b00000, W_ALL1, 1'b1, 5'b00000, 3'd0);
        // Sole requester q2 is regranted after its packet.
        add(5'b00100, W_ALL1, 1'b0, 5'b00100, 3'd2);
        add(5'b00100, W_ALL1, 1'b1, 5'b00100, 3'd2);
        add(5'b00000, W_ALL1, 1'b1, 5'b00000, 3'd0);
        // q0 weight 3, q1 weight 1, single-beat packets: 0,0,0,1,0,0,0,1.
        add(5'b00011, 20'h11113, 1'b0, 5'b00001, 3'd0);
        add(5'b00011, 20'h11113, 1'b1, 5'b00001, 3'd0);
        add(5'b00011, 20'h11113, 1'b1, 5'b00001, 3'd0);
        add(5'b00011, 20'h11113, 1'b1, 5'b00010, 3'd1);
        add(5'b00011, 20'h11113, 1'b1, 5'b00001, 3'd0);
        add(5'b00011, 20'h11113, 1'b1, 5'b00001, 3'd0);
        add(5'b00011, 20'h11113, 1'b1, 5'b00001, 3'd0);
        add(5'b00011, 20'h11113, 1'b1, 5'b00010, 3'd1);
        add(5'b00000, 20'h11113, 1'b1, 5'b00000, 3'd0);

        tick();
        tick();
        check_grant("reset", 5'b0, 3'd0);
        check("reset.cnt_out", 32'(cnt_out), 32'h0);
        axis_reset = 1'b0;
        tick();
        check_grant("post_reset_idle", 5'b0, 3'd0);

        foreach (vecs[i]) begin
            req        = vecs[i].req;
            weight_cfg = vecs[i].wcfg;
            pkt_end    = vecs[i].pe;
            tick();
            check_grant($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_idx);
        end

        // q3 weight 0: never granted, pkt_end in IDLE ignored.
        req        = 5'b01000;
        weight_cfg = 20'h10111;
        for (int c = 0; c < 100; c++) begin
            pkt_end = c[0];
            tick();
            check("w0_no_grant", 32'(grant), 32'h0);
        end
        pkt_end    = 1'b0;
        weight_cfg = 20'h12111;
        tick();
        check_grant("w2_grant", 5'b01000, 3'd3);
        pkt_end = 1'b1;
        tick();
        check_grant("w2_second_pkt", 5'b01000, 3'd3);
        req = 5'b00000;
        tick();
        check_grant("w2_to_idle", 5'b00000, 3'd0);

        // Grant q1, swap requests mid-packet; grant frozen until pkt_end.
        weight_cfg = W_ALL1;
        pkt_end    = 1'b0;
        req        = 5'b00010;
        tick();
        check_grant("hold_q1_start", 5'b00010, 3'd1);
        req = 5'b10000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_grant("hold_q1", 5'b00010, 3'd1);
        end
        pkt_end = 1'b1;
        tick();
        check_grant("switch_q4", 5'b10000, 3'd4);

        // Asynchronous reset mid-packet, then q0 first after release.
        pkt_end = 1'b0;
        req     = 5'b11111;
        #3;
        axis_reset = 1'b1;
        #1;
        check_grant("async_reset", 5'b0, 3'd0);
        tick();
        check_grant("in_reset", 5'b0, 3'd0);
        axis_reset = 1'b0;
        tick();
        check_grant("release_edge1", 5'b0, 3'd0);
        tick();
        check_grant("release_edge2_q0", 5'b00001, 3'd0);

        // Packet counters: one packet on q0, then packets on q2.
        req     = 5'b00100;
        pkt_end = 1'b1;
        tick();
        check_grant("cnt_q2_grant", 5'b00100, 3'd2);
        for (int c = 0; c < 5; c++) begin
            tick();
        end
        pkt_end = 1'b0;
        cnt_sel = 3'd2;
        tick();
        check("cnt_q2_5", 32'(cnt_out), CNT_EN ? 32'd5 : 32'd0);
        cnt_sel = 3'd0;
        tick();
        check("cnt_q0_1", 32'(cnt_out), CNT_EN ? 32'd1 : 32'd0);
        cnt_sel = 3'd7;
        tick();
        check("cnt_out_of_range", 32'(cnt_out), 32'd0);
        cnt_sel = 3'd2;
        pkt_end = 1'b1;
        for (int c = 0; c < 65535; c++) begin
            tick();
        end
        pkt_end = 1'b0;
        tick();
        tick();
        check("cnt_q2_saturated", 32'(cnt_out), CNT_EN ? 32'hFFFF : 32'd0);
        check_grant("cnt_q2_still_granted", 5'b00100, 3'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
